// File: rtl/rob_if.sv
// Dispatch, writeback and commit signals shared between the reorder buffer and its neighbours.
// The master side is the pipeline around the ROB; the slave side is the ROB itself.
interface rob_if #(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
);
  localparam int CNT_W = $clog2(ROB_DEPTH) + 1;

  logic              flush;
  logic              alloc_valid;
  logic [REG_W-1:0]  alloc_dest;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic [TAG_W-1:0]  alu_target;
  logic [DATA_W-1:0] alu_result;
  logic [TAG_W-1:0]  fwd_target;
  logic [DATA_W-1:0] fwd_result;
  logic              commit_valid;
  logic              commit_ready;
  logic [TAG_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, alloc_valid, alloc_dest, alu_target, alu_result,
           fwd_target, fwd_result, commit_ready,
    input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_dest,
           commit_data, count
  );

  modport slave (
    input  flush, alloc_valid, alloc_dest, alu_target, alu_result,
           fwd_target, fwd_result, commit_ready,
    output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_dest,
           commit_data, count
  );
endinterface

// File: rtl/rob.sv
// Circular reorder buffer: allocates tags in order, accepts out-of-order results from two
// writeback buses and retires completed entries strictly in allocation order.
module rob #(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 4,
  parameter int DATA_W    = 32,
  parameter int REG_W     = 5
) (
  input  logic clk,
  input  logic rst,
  rob_if.slave bus
);
  localparam int PTR_W = $clog2(ROB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [TAG_W-1:0] TAG_INVALID = '1;
  localparam logic [TAG_W:0]   DEPTH_T     = (TAG_W + 1)'(ROB_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(ROB_DEPTH);

  logic [ROB_DEPTH-1:0] busy;
  logic [ROB_DEPTH-1:0] done;
  logic [REG_W-1:0]     dest_q [ROB_DEPTH];
  logic [DATA_W-1:0]    data_q [ROB_DEPTH];
  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count_q;

  logic             alloc_ready;
  logic             alloc_fire;
  logic             commit_valid;
  logic             commit_fire;
  logic [PTR_W-1:0] alu_idx;
  logic [PTR_W-1:0] fwd_idx;
  logic             alu_ok;
  logic             fwd_ok;

  assign alloc_ready  = count_q < DEPTH_C;
  assign alloc_fire   = bus.alloc_valid && alloc_ready;
  assign commit_valid = busy[head] && done[head];
  assign commit_fire  = commit_valid && bus.commit_ready;
  assign alu_idx      = bus.alu_target[PTR_W-1:0];
  assign fwd_idx      = bus.fwd_target[PTR_W-1:0];

  // A writeback only lands on a live entry that is not being re-allocated this cycle;
  // when both buses hit the same entry the ALU bus takes it.
  always_comb begin
    alu_ok = 1'b0;
    fwd_ok = 1'b0;
    if (bus.alu_target != TAG_INVALID && {1'b0, bus.alu_target} < DEPTH_T)
      alu_ok = busy[alu_idx] && !(alloc_fire && alu_idx == tail);
    if (bus.fwd_target != TAG_INVALID && {1'b0, bus.fwd_target} < DEPTH_T)
      fwd_ok = busy[fwd_idx] && !(alloc_fire && fwd_idx == tail) &&
               !(alu_ok && alu_idx == fwd_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      busy    <= '0;
      done    <= '0;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + 1'b1;
      end
      if (fwd_ok)
        done[fwd_idx] <= 1'b1;
      if (alu_ok)
        done[alu_idx] <= 1'b1;
      if (commit_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload arrays carry no reset; the busy/done bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (alloc_fire)
      dest_q[tail] <= bus.alloc_dest;
    if (fwd_ok)
      data_q[fwd_idx] <= bus.fwd_result;
    if (alu_ok)
      data_q[alu_idx] <= bus.alu_result;
  end

  assign bus.alloc_ready  = alloc_ready;
  assign bus.alloc_tag    = TAG_W'(tail);
  assign bus.commit_valid = commit_valid;
  assign bus.commit_tag   = TAG_W'(head);
  assign bus.commit_dest  = dest_q[head];
  assign bus.commit_data  = data_q[head];
  assign bus.count        = count_q;
endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: fill, out-of-order completion, bus collision,
// full-plus-retire wrap, stale/invalid tags, and flush/reset mid-operation.
module tb_rob;
  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = 4;
  localparam int DATA_W    = 32;
  localparam int REG_W     = 5;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  rob_if #(.ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  rob #(.ROB_DEPTH(ROB_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task step;
    @(posedge clk);
    #1;
  endtask

  task idle;
    bus.flush        = 1'b0;
    bus.alloc_valid  = 1'b0;
    bus.alloc_dest   = '0;
    bus.alu_target   = 4'hF;
    bus.alu_result   = '0;
    bus.fwd_target   = 4'hF;
    bus.fwd_result   = '0;
    bus.commit_ready = 1'b0;
  endtask

  task do_reset;
    idle();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task alloc_n(input int n, input int dest_base);
    bus.alloc_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.alloc_dest = REG_W'(dest_base + i);
      step();
    end
    bus.alloc_valid = 1'b0;
  endtask

  task wb(input logic [3:0] at, input logic [31:0] ad, input logic [3:0] ft, input logic [31:0] fd);
    bus.alu_target = at;
    bus.alu_result = ad;
    bus.fwd_target = ft;
    bus.fwd_result = fd;
    step();
    bus.alu_target = 4'hF;
    bus.fwd_target = 4'hF;
  endtask

  task test_reset;
    do_reset();
    tests_run++; if (bus.count !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); end
    tests_run++; if (bus.alloc_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_alloc_ready: got %0b expected 1", bus.alloc_ready); end
    tests_run++; if (bus.alloc_tag !== 4'd0) begin tests_failed++; $display("[TB] FAIL reset_alloc_tag: got %0d expected 0", bus.alloc_tag); end
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_commit_valid: got %0b expected 0", bus.commit_valid); end
  endtask

  task test_fill_and_wrap;
    do_reset();
    for (int i = 0; i < ROB_DEPTH; i++) begin
      tests_run++; if (bus.alloc_tag !== 4'(i)) begin tests_failed++; $display("[TB] FAIL fill_tag: got %0d expected %0d", bus.alloc_tag, i); end
      bus.alloc_valid = 1'b1;
      bus.alloc_dest  = REG_W'(i);
      step();
    end
    bus.alloc_valid = 1'b0;
    tests_run++; if (bus.count !== 4'd8) begin tests_failed++; $display("[TB] FAIL fill_count: got %0d expected 8", bus.count); end
    tests_run++; if (bus.alloc_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_alloc_ready: got %0b expected 0", bus.alloc_ready); end
    alloc_n(1, 31);
    tests_run++; if (bus.count !== 4'd8) begin tests_failed++; $display("[TB] FAIL full_reject_count: got %0d expected 8", bus.count); end
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_no_done: got %0b expected 0", bus.commit_valid); end
    wb(4'd0, 32'h50, 4'hF, 32'h0);
    tests_run++; if (bus.commit_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_head_valid: got %0b expected 1", bus.commit_valid); end
    tests_run++; if (bus.commit_data !== 32'h50) begin tests_failed++; $display("[TB] FAIL full_head_data: got %0h expected 50", bus.commit_data); end
    tests_run++; if (bus.commit_dest !== 5'd0) begin tests_failed++; $display("[TB] FAIL full_head_dest: got %0d expected 0", bus.commit_dest); end
    bus.commit_ready = 1'b1;
    bus.alloc_valid  = 1'b1;
    bus.alloc_dest   = 5'd30;
    step();
    bus.commit_ready = 1'b0;
    bus.alloc_valid  = 1'b0;
    tests_run++; if (bus.count !== 4'd7) begin tests_failed++; $display("[TB] FAIL simul_count: got %0d expected 7", bus.count); end
    tests_run++; if (bus.alloc_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL simul_alloc_ready: got %0b expected 1", bus.alloc_ready); end
    tests_run++; if (bus.alloc_tag !== 4'd0) begin tests_failed++; $display("[TB] FAIL simul_wrap_tag: got %0d expected 0", bus.alloc_tag); end
    tests_run++; if (bus.commit_tag !== 4'd1) begin tests_failed++; $display("[TB] FAIL simul_head_tag: got %0d expected 1", bus.commit_tag); end
  endtask

  task test_out_of_order;
    do_reset();
    alloc_n(3, 10);
    wb(4'd2, 32'h22, 4'hF, 32'h0);
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ooo_after2_valid: got %0b expected 0", bus.commit_valid); end
    wb(4'hF, 32'h0, 4'd1, 32'h11);
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ooo_after1_valid: got %0b expected 0", bus.commit_valid); end
    bus.commit_ready = 1'b1;
    wb(4'd0, 32'h00, 4'hF, 32'h0);
    tests_run++; if (bus.count !== 4'd3) begin tests_failed++; $display("[TB] FAIL ooo_no_same_cycle_retire: got %0d expected 3", bus.count); end
    for (int k = 0; k < 3; k++) begin
      tests_run++; if (bus.commit_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL ooo_valid_%0d: got %0b expected 1", k, bus.commit_valid); end
      tests_run++; if (bus.commit_tag !== 4'(k)) begin tests_failed++; $display("[TB] FAIL ooo_tag_%0d: got %0d expected %0d", k, bus.commit_tag, k); end
      tests_run++; if (bus.commit_data !== 32'(32'h11 * k)) begin tests_failed++; $display("[TB] FAIL ooo_data_%0d: got %0h expected %0h", k, bus.commit_data, 32'h11 * k); end
      tests_run++; if (bus.commit_dest !== 5'(10 + k)) begin tests_failed++; $display("[TB] FAIL ooo_dest_%0d: got %0d expected %0d", k, bus.commit_dest, 10 + k); end
      step();
    end
    bus.commit_ready = 1'b0;
    tests_run++; if (bus.count !== 4'd0) begin tests_failed++; $display("[TB] FAIL ooo_drained_count: got %0d expected 0", bus.count); end
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL ooo_drained_valid: got %0b expected 0", bus.commit_valid); end
  endtask

  task test_collision_and_hold;
    do_reset();
    alloc_n(4, 20);
    wb(4'd0, 32'h100, 4'd1, 32'h101);
    wb(4'd2, 32'h102, 4'hF, 32'h0);
    wb(4'd3, 32'hAAAA, 4'd3, 32'hBBBB);
    bus.commit_ready = 1'b1;
    step(); step(); step();
    bus.commit_ready = 1'b0;
    tests_run++; if (bus.count !== 4'd1) begin tests_failed++; $display("[TB] FAIL coll_count: got %0d expected 1", bus.count); end
    tests_run++; if (bus.commit_tag !== 4'd3) begin tests_failed++; $display("[TB] FAIL coll_tag: got %0d expected 3", bus.commit_tag); end
    tests_run++; if (bus.commit_data !== 32'hAAAA) begin tests_failed++; $display("[TB] FAIL coll_alu_wins: got %0h expected aaaa", bus.commit_data); end
    step(); step();
    tests_run++; if (bus.commit_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_valid: got %0b expected 1", bus.commit_valid); end
    tests_run++; if (bus.commit_data !== 32'hAAAA) begin tests_failed++; $display("[TB] FAIL hold_data: got %0h expected aaaa", bus.commit_data); end
    tests_run++; if (bus.commit_dest !== 5'd23) begin tests_failed++; $display("[TB] FAIL hold_dest: got %0d expected 23", bus.commit_dest); end
    tests_run++; if (bus.count !== 4'd1) begin tests_failed++; $display("[TB] FAIL hold_count: got %0d expected 1", bus.count); end
  endtask

  task test_stale_invalid;
    do_reset();
    alloc_n(2, 0);
    wb(4'd5, 32'h55, 4'hF, 32'h66);
    tests_run++; if (bus.count !== 4'd2) begin tests_failed++; $display("[TB] FAIL stale_count: got %0d expected 2", bus.count); end
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL stale_valid: got %0b expected 0", bus.commit_valid); end
    alloc_n(6, 2);
    wb(4'hF, 32'h77, 4'hD, 32'h5D);
    tests_run++; if (bus.count !== 4'd8) begin tests_failed++; $display("[TB] FAIL invalid_count: got %0d expected 8", bus.count); end
    for (int i = 0; i < 5; i++) wb(4'(i), 32'(i), 4'hF, 32'h0);
    bus.commit_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.commit_ready = 1'b0;
    tests_run++; if (bus.commit_tag !== 4'd5) begin tests_failed++; $display("[TB] FAIL range_head_tag: got %0d expected 5", bus.commit_tag); end
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL range_tag5_not_done: got %0b expected 0", bus.commit_valid); end
    wb(4'd5, 32'h5, 4'd6, 32'h6);
    bus.commit_ready = 1'b1;
    step(); step();
    bus.commit_ready = 1'b0;
    tests_run++; if (bus.commit_tag !== 4'd7) begin tests_failed++; $display("[TB] FAIL invalid_head_tag: got %0d expected 7", bus.commit_tag); end
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL invalid_tag7_not_done: got %0b expected 0", bus.commit_valid); end
    tests_run++; if (bus.count !== 4'd1) begin tests_failed++; $display("[TB] FAIL invalid_final_count: got %0d expected 1", bus.count); end
  endtask

  task automatic test_discard(input bit use_rst);
    string nm;
    nm = use_rst ? "rst" : "flush";
    do_reset();
    alloc_n(4, 4);
    wb(4'd0, 32'hE0, 4'd1, 32'hE1);
    tests_run++; if (bus.commit_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_pre_valid: got %0b expected 1", nm, bus.commit_valid); end
    bus.alloc_valid = 1'b1;
    if (use_rst) rst = 1'b0;
    else bus.flush = 1'b1;
    step();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.alloc_valid = 1'b0;
    tests_run++; if (bus.count !== 4'd0) begin tests_failed++; $display("[TB] FAIL %s_count: got %0d expected 0", nm, bus.count); end
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_commit_valid: got %0b expected 0", nm, bus.commit_valid); end
    tests_run++; if (bus.alloc_tag !== 4'd0) begin tests_failed++; $display("[TB] FAIL %s_alloc_tag: got %0d expected 0", nm, bus.alloc_tag); end
    tests_run++; if (bus.alloc_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_alloc_ready: got %0b expected 1", nm, bus.alloc_ready); end
    bus.commit_ready = 1'b1;
    step(); step();
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_idle_valid: got %0b expected 0", nm, bus.commit_valid); end
    alloc_n(1, 9);
    tests_run++; if (bus.count !== 4'd1) begin tests_failed++; $display("[TB] FAIL %s_realloc_count: got %0d expected 1", nm, bus.count); end
    tests_run++; if (bus.commit_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL %s_no_old_retire: got %0b expected 0", nm, bus.commit_valid); end
    bus.commit_ready = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b0;
    idle();
    test_reset();
    test_fill_and_wrap();
    test_out_of_order();
    test_collision_and_hold();
    test_stale_invalid();
    test_discard(1'b0);
    test_discard(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
